// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum reduction controller: FSM encoding
// and the width growth of the lane sum and the group accumulator.
package psum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // 8 lanes add 3 bits; up to 16 vectors add 4 more
  localparam int LANE_GROW = 3;
  localparam int ACC_GROW  = 7;

  function automatic int lane_sum_w(input int bw_psum);
    return bw_psum + LANE_GROW;
  endfunction

  function automatic int acc_w(input int bw_psum);
    return bw_psum + ACC_GROW;
  endfunction

endpackage

// File: rtl/col_sum_tree.sv
// Combinational sum of col signed lanes: carry-save compression of the
// sign-extended lanes followed by one carry-propagate add.
module col_sum_tree #(
  parameter int col    = 8,
  parameter int bw_in  = 20,
  parameter int bw_out = 23
) (
  input  logic [col-1:0][bw_in-1:0] lanes,
  output logic [bw_out-1:0]         sum
);

  logic [bw_out-1:0] ops [col];
  logic [bw_out-1:0] cs_s, cs_c, cs_t;

  generate
    for (genvar k = 0; k < col; k++) begin : g_ext
      assign ops[k] = {{(bw_out-bw_in){lanes[k][bw_in-1]}}, lanes[k]};
    end
  endgenerate

  // Wraparound in the sum/carry words is harmless: the true total fits bw_out
  always_comb begin
    cs_s = '0;
    cs_c = '0;
    cs_t = '0;
    for (int k = 0; k < col; k++) begin
      cs_t = cs_s ^ cs_c ^ ops[k];
      cs_c = ((cs_s & cs_c) | (cs_s & ops[k]) | (cs_c & ops[k])) << 1;
      cs_s = cs_t;
    end
    sum = cs_s + cs_c;
  end

endmodule

// File: rtl/psum_reduce_ctrl.sv
// Reduces groups of 1..2^len_bw psum vectors to one signed total, with a
// registered lane-sum stage, a group accumulator and a held output.
module psum_reduce_ctrl
  import psum_pkg::*;
#(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int len_bw  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [len_bw-1:0]          cfg_len,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [bw_psum*col-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [bw_psum+ACC_GROW-1:0] out_data,
  output logic                       busy
);

  localparam int SW = lane_sum_w(bw_psum);
  localparam int AW = acc_w(bw_psum);

  state_t state, state_nxt;

  logic [col-1:0][bw_psum-1:0] lanes;
  logic [SW-1:0]     lane_sum;
  logic [len_bw-1:0] len_q, cnt;
  logic              accept, first, last;
  logic              s1_vld, s1_first, s1_last;
  logic [SW-1:0]     s1_sum;
  logic [AW-1:0]     s1_ext, acc;

  assign lanes = in_data;

  col_sum_tree #(
    .col    (col),
    .bw_in  (bw_psum),
    .bw_out (SW)
  ) u_tree (
    .lanes (lanes),
    .sum   (lane_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    in_ready  = !reset && !flush && (state != ST_HOLD);
    accept    = in_valid && in_ready;
    case (state)
      ST_IDLE: if (accept) begin
        first     = 1'b1;
        last      = (cfg_len == '0);
        state_nxt = last ? ST_HOLD : ST_ACC;
      end
      ST_ACC: if (accept) begin
        // cnt holds accepts so far; this accept makes it len_q+1
        last = (cnt == len_q);
        if (last) state_nxt = ST_HOLD;
      end
      ST_HOLD: if (out_valid && out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  assign s1_ext = {{(AW-SW){s1_sum[SW-1]}}, s1_sum};

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      len_q     <= '0;
      cnt       <= '0;
      s1_vld    <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        if (first) begin
          len_q <= cfg_len;
          cnt   <= len_bw'(1);
        end else begin
          cnt <= cnt + len_bw'(1);
        end
        if (last) cnt <= '0;
        s1_sum <= lane_sum;
      end
      s1_vld   <= accept;
      s1_first <= first;
      s1_last  <= last;
      if (s1_vld) acc <= s1_first ? s1_ext : acc + s1_ext;
      if (s1_vld && s1_last)         out_valid <= 1'b1;
      else if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

  assign out_data = acc;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_psum_reduce_ctrl.sv
// Directed bench for psum_reduce_ctrl: latency, group sums, stall, flush, reset.
module tb_psum_reduce_ctrl;
  localparam int COL = 8, BW = 20, LB = 4, W = BW*COL, AW = BW+7;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [LB-1:0] cfg_len;
  logic [W-1:0] in_data;
  logic in_ready, out_valid, busy;
  logic [AW-1:0] out_data;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  psum_reduce_ctrl #(.col(COL), .bw_psum(BW), .len_bw(LB)) dut (
    .clk(clk), .reset(reset), .cfg_len(cfg_len), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  function automatic logic [W-1:0] fill(input logic [BW-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_len = '0; in_data = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    reset = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    cfg_len = 4'd0; in_data = fill(20'd1); in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", in_ready); end
    tick(); in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_lat1 got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_hold got=%b%b exp=01", in_ready, busy); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_lat2 got=%b exp=1", out_valid); end
    checks++; if ($signed(out_data) !== 27'sd8) begin failures++; $display("FAIL single_data got=%0d exp=8", $signed(out_data)); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL single_done got=%b%b%b exp=001", out_valid, busy, in_ready); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    cfg_len = 4'd3; in_data = fill(20'hFFFFF); in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
      tick();
      cfg_len = 4'd0;  // mid-group change must be ignored
    end
    in_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_after got=%b%b exp=00", in_ready, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL b2b_valid got=%b%b exp=10", out_valid, in_ready); end
    checks++; if ($signed(out_data) !== -27'sd32) begin failures++; $display("FAIL b2b_data got=%0d exp=-32", $signed(out_data)); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_release got=%b exp=1", in_ready); end
    wait_out(ok);  // no stray group must appear
    checks++; if (ok !== 1'b0) begin failures++; $display("FAIL b2b_stray got=%b exp=0", ok); end
  endtask

  task automatic test_max();
    bit ok;
    cfg_len = 4'd15; in_data = fill(20'h7FFFF); in_valid = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    in_valid = 1'b0;
    wait_out(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL max_timeout got=%b exp=1", ok); end
    checks++; if ($signed(out_data) !== 27'sd67108736) begin failures++; $display("FAIL max_data got=%0d exp=67108736", $signed(out_data)); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit ok;
    logic [W-1:0] v;
    for (int k = 0; k < COL; k++) v[k*BW +: BW] = BW'(k + 1);
    cfg_len = 4'd1; in_data = v; in_valid = 1'b1;
    tick(); tick();
    in_data = fill(20'd1); cfg_len = 4'd0;  // in_valid stays high while blocked
    wait_out(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_timeout got=%b exp=1", ok); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || $signed(out_data) !== 27'sd72 || in_ready !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d got=%b/%0d/%b exp=1/72/0", i, out_valid, $signed(out_data), in_ready); end
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0; #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=%b%b exp=10", in_ready, out_valid); end
    tick(); in_valid = 1'b0;
    wait_out(ok);
    checks++; if (ok !== 1'b1 || $signed(out_data) !== 27'sd8) begin failures++; $display("FAIL stall_next got=%b/%0d exp=1/8", ok, $signed(out_data)); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bit ok;
    cfg_len = 4'd3; in_data = fill(20'd7); in_valid = 1'b1;
    tick(); tick();
    flush = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_idle got=%b%b exp=00", busy, out_valid); end
    cfg_len = 4'd0; in_data = '0; in_data[BW-1:0] = 20'd5; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    wait_out(ok);
    checks++; if (ok !== 1'b1 || $signed(out_data) !== 27'sd5) begin failures++; $display("FAIL flush_next got=%b/%0d exp=1/5", ok, $signed(out_data)); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    cfg_len = 4'd3; in_data = fill(20'd9); in_valid = 1'b1;
    tick(); tick(); in_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin failures++; $display("FAIL rstmid_acc got=%b%b/%0d exp=00/0", busy, out_valid, out_data); end
    cfg_len = 4'd0; in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_out(ok);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    checks++; if (ok !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin failures++; $display("FAIL rstmid_hold got=%b%b%b/%0d exp=100/0", ok, busy, out_valid, out_data); end
    cfg_len = 4'd1; in_data = fill(20'd2); in_valid = 1'b1;
    tick(); tick(); in_valid = 1'b0;
    wait_out(ok);
    checks++; if (ok !== 1'b1 || $signed(out_data) !== 27'sd32) begin failures++; $display("FAIL rstmid_next got=%b/%0d exp=1/32", ok, $signed(out_data)); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_max();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/psum_reduce_ctrl.md
PSUM_REDUCE_CTRL -- requirements
Module: psum_reduce_ctrl

Interface
REQ-001 SHALL have parameter col, default 8, meaning number of psum columns per input vector.
REQ-002 SHALL have parameter bw_psum, default 20, meaning width of one signed psum lane.
REQ-003 SHALL have parameter len_bw, default 4, meaning width of the group-length field; maximum group is 2^len_bw vectors.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cfg_len  input  len_bw  vectors per group minus one (0 means 1 vector, 15 means 16 vectors).
REQ-007 SHALL have port flush  input  1  synchronous abort of the current group.
REQ-008 SHALL have port in_valid  input  1  in_data is valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port in_data  input  bw_psum*col  col signed lanes; lane k is bits [bw_psum*(k+1)-1 : bw_psum*k].
REQ-011 SHALL have port out_valid  output  1  out_data holds a completed group sum.
REQ-012 SHALL have port out_ready  input  1  downstream takes out_data.
REQ-013 SHALL have port out_data  output  bw_psum+7  signed sum of all lanes of all vectors in the group.
REQ-014 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-015 SHALL accept a vector only on a cycle with in_valid=1 and in_ready=1 (accept).
REQ-016 SHALL reduce each accepted vector to one signed bw_psum+3-bit lane sum, with every lane sign-extended; no truncation.
REQ-017 SHALL register the lane sum in one pipeline stage (stage-1 value, stage-1 valid).
REQ-018 SHALL hold a signed bw_psum+7-bit accumulator; the stage-1 sum of the first vector of a group loads it, and each later stage-1 sum adds to it, sign-extended, modulo 2^(bw_psum+7).
REQ-019 SHALL implement a state machine with states IDLE, ACC and HOLD.
REQ-020 SHALL drive in_ready=1 in IDLE and ACC and in_ready=0 in HOLD and on any cycle with flush=1.
REQ-021 SHALL latch cfg_len on the first accept of a group (in IDLE); changes to cfg_len mid-group SHALL have no effect.
REQ-022 SHALL count accepts per group; IDLE->ACC on the first accept when the latched length is >0; IDLE->HOLD on the first accept when the length is 0; ACC->HOLD on the accept that makes count equal to length+1.
REQ-023 SHALL assert out_valid exactly 2 cycles after the final accept of a group and hold out_valid and out_data stable until out_valid=1 and out_ready=1.
REQ-024 SHALL go HOLD->IDLE on the out_valid/out_ready handshake; the earliest next accept SHALL be the cycle after that handshake.
REQ-025 SHALL, on flush=1 in any state, go to IDLE next cycle, clear the counter, stage-1 valid and out_valid, and discard the accumulator; flush SHALL take priority over a same-cycle accept or output handshake.
REQ-026 SHALL ignore in_data on cycles with in_valid=0, and SHALL keep the accumulator unchanged on cycles without a stage-1 valid.

Reset
REQ-027 SHALL, while reset=1, force state=IDLE, counter=0, stage-1 valid=0, out_valid=0, out_data=0, busy=0; in_ready SHALL read 0 during reset.
REQ-028 SHALL discard any partially accumulated group when reset is asserted mid-operation; the first accept after reset deassertion SHALL start a new group.

Structure
REQ-029 SHALL place the state encoding and the derived widths (bw_psum+3, bw_psum+7) in a shared package, psum_pkg.
REQ-030 SHALL instantiate one combinational sub-module, col_sum_tree (a col-input carry-save reduction with a final carry-propagate add), for the lane sum.

Verification
REQ-031 SHALL cover: cfg_len=0, one vector with all lanes=1 -> out_valid 2 cycles after the accept, out_data=8.
REQ-032 SHALL cover: cfg_len=3, four back-to-back vectors, all lanes=-1 (0xFFFFF) -> out_data=-32; in_ready low from the cycle after the 4th accept until the handshake.
REQ-033 SHALL cover: cfg_len=15, 16 vectors with all lanes=+(2^19-1) -> out_data=16*8*524287=67108736, no overflow.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles with out_valid=1 -> out_data stable; in_valid=1 with in_ready=0 -> no accept; group completes after out_ready=1.
REQ-035 SHALL cover: flush after 2 of 4 vectors, then a new cfg_len=0 group with lane0=5 and other lanes 0 -> out_data=5 (no residue).
REQ-036 SHALL cover: reset asserted for 1 cycle mid-group and mid-HOLD -> all outputs at reset values next cycle; a subsequent group sums correctly.
